// File: rtl/clk_div_gen.sv
// Programmable clock divider: square out_clk, toggle strobe, glitch-free divisor reload at wraps.
// Define CLKDIV_FRAC_EN to add a fractional accumulator that stretches selected half-periods.
module clk_div_gen #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 260,
  parameter int FRAC_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_in,
  input  logic [FRAC_W-1:0] frac_in,
  input  logic              div_load,
  output logic              div_ack,
  output logic              out_clk,
  output logic              tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] stage_div_q, stage_div_d;
  logic             pend_q, pend_d;
  logic             out_clk_q, out_clk_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             at_limit;
  logic             wrap;

`ifdef CLKDIV_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] stage_frac_q, stage_frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] frac_nxt;
  logic [FRAC_W:0]   acc_sum;
  logic              ext_q, ext_d;

  // A carried half-period holds cnt at div_r for one extra cycle instead of
  // counting to div_r+1, so the comparison never needs a wider counter.
  assign at_limit = (cnt_q == div_q);
  assign wrap     = en && at_limit && !ext_q;
  assign frac_nxt = pend_q ? stage_frac_q : frac_q;
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_nxt};
`else
  logic unused_frac;

  assign unused_frac = ^frac_in;
  assign at_limit    = (cnt_q == div_q);
  assign wrap        = en && at_limit;
`endif

  // NOTE: every signal gets a default at the top of the comb block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    stage_div_d = stage_div_q;
    pend_d      = pend_q;
    out_clk_d   = out_clk_q;
    tick_d      = 1'b0;
    ack_d       = 1'b0;
`ifdef CLKDIV_FRAC_EN
    frac_d       = frac_q;
    stage_frac_d = stage_frac_q;
    acc_d        = acc_q;
    ext_d        = ext_q;
`endif

    if (wrap) begin
      cnt_d     = '0;
      out_clk_d = ~out_clk_q;
      tick_d    = 1'b1;
      if (pend_q) begin
        div_d  = stage_div_q;
        ack_d  = 1'b1;
        pend_d = 1'b0;
      end
`ifdef CLKDIV_FRAC_EN
      frac_d = frac_nxt;
      acc_d  = acc_sum[FRAC_W-1:0];
      ext_d  = acc_sum[FRAC_W];
`endif
    end else if (en) begin
      if (!at_limit) begin
        cnt_d = cnt_q + 1'b1;
      end
`ifdef CLKDIV_FRAC_EN
      else begin
        ext_d = 1'b0;
      end
`endif
    end

    // A load coinciding with a wrap stages for the next wrap; the value
    // pending before it has already been consumed above.
    if (div_load) begin
      stage_div_d = div_in;
      pend_d      = 1'b1;
`ifdef CLKDIV_FRAC_EN
      stage_frac_d = frac_in;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      div_q       <= DEF_DIV;
      stage_div_q <= '0;
      pend_q      <= 1'b0;
      out_clk_q   <= 1'b0;
      tick_q      <= 1'b0;
      ack_q       <= 1'b0;
`ifdef CLKDIV_FRAC_EN
      frac_q       <= '0;
      stage_frac_q <= '0;
      acc_q        <= '0;
      ext_q        <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      stage_div_q <= stage_div_d;
      pend_q      <= pend_d;
      out_clk_q   <= out_clk_d;
      tick_q      <= tick_d;
      ack_q       <= ack_d;
`ifdef CLKDIV_FRAC_EN
      frac_q       <= frac_d;
      stage_frac_q <= stage_frac_d;
      acc_q        <= acc_d;
      ext_q        <= ext_d;
`endif
    end
  end

  assign out_clk = out_clk_q;
  assign tick    = tick_q;
  assign div_ack = ack_q;

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, divide counter/divisor width.
REQ-002 SHALL have parameter DEFAULT_DIV, default 260, divisor loaded at reset (50 MHz -> ~96 kHz out_clk, 192 kHz tick).
REQ-003 SHALL have parameter FRAC_W, default 8, fractional accumulator width.
REQ-004 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  count enable; low freezes all state.
REQ-007 SHALL have port div_in  input  CNT_W  new divisor value.
REQ-008 SHALL have port frac_in  input  FRAC_W  new fractional increment.
REQ-009 SHALL have port div_load  input  1  one-cycle request to stage div_in/frac_in.
REQ-010 SHALL have port div_ack  output  1  one-cycle pulse when staged values take effect.
REQ-011 SHALL have port out_clk  output  1  divided square clock, registered.
REQ-012 SHALL have port tick  output  1  one-cycle strobe on every out_clk toggle.

Function
REQ-013 SHALL hold active divisor div_r and counter cnt (CNT_W bits each); when en=1 and cnt!=limit, cnt increments by 1.
REQ-014 SHALL, when en=1 and cnt==limit, toggle out_clk, set cnt to 0 and assert tick for exactly that next cycle; limit = div_r (or div_r+1, see REQ-024).
REQ-015 SHALL give half-period div_r+1 cycles and out_clk period 2*(div_r+1) cycles when fractional mode absent or frac=0.
REQ-016 SHALL accept div_r=0: out_clk toggles and tick asserts every enabled cycle.
REQ-017 SHALL, on div_load=1, capture div_in/frac_in into a staging register and set a pending flag, regardless of en.
REQ-018 SHALL apply staged values to div_r/frac_r only at a wrap (cnt==limit with en=1), never mid half-period; pulse div_ack the same cycle the new values become active.
REQ-019 SHALL, on a second div_load while pending, overwrite staging with the latest value; only one div_ack issued.
REQ-020 SHALL, when div_load coincides with a wrap, stage the new value and apply it at the following wrap; any previously pending value applies at the current wrap.
REQ-021 SHALL, with en=0, hold cnt, out_clk, accumulator, pending flag; tick and div_ack low.
REQ-022 SHALL keep counter comparison exact: no cnt overflow for any div_r up to 2^CNT_W-1.

Reset
REQ-023 SHALL, on rst low (asynchronous, any time incl. mid half-period): cnt=0, out_clk=0, tick=0, div_ack=0, div_r=DEFAULT_DIV, frac_r=0, accumulator=0, staging cleared, pending=0; operation resumes on first posedge clk after rst high.

Configuration
REQ-024 SHALL, with macro CLKDIV_FRAC_EN defined, add frac_r to a FRAC_W-bit accumulator at each wrap; on carry-out the next half-period limit is div_r+1 (one cycle longer), else div_r.
REQ-025 SHALL, with CLKDIV_FRAC_EN undefined, ignore frac_in, omit accumulator, and use limit=div_r always; all other behaviour identical.

Verification
REQ-026 SHALL test default: reset release, en=1 -> tick every 261 cycles, out_clk period 522 cycles, first out_clk rise 261 cycles after enable.
REQ-027 SHALL test reload: div_load with div_in=3 mid half-period -> current half-period finishes at 261 cycles, div_ack pulses once at that wrap, then out_clk period 8 cycles.
REQ-028 SHALL test back-to-back loads 5 then 9 before a wrap -> single div_ack, div_r=9, half-period 10 cycles; div_in=0 -> tick every cycle.
REQ-029 SHALL test en low for 50 cycles mid half-period -> cnt/out_clk frozen, no tick; half-period completes with total 261 enabled cycles.
REQ-030 SHALL test rst pulse mid operation with pending load -> out_clk=0 immediately, div_ack never issued, divisor back to 260.
REQ-031 SHALL test (CLKDIV_FRAC_EN, FRAC_W=8) div_in=260, frac_in=0x80 -> half-periods alternate 261/262 cycles, average out_clk period 523 cycles; without macro -> constant 261.
